// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_arb_pkg
// Description : Shared widths, the hard-wired zero register index and the
//               register address/data types for the register file read
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    // Register 31 reads through the mux unchanged and is never forwarded.
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter_if
// Description : Bundle of the requester handshake, the read-mux select/data
//               pair, the write-port observation signals and the tagged read
//               response of the register file read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][ADDR_W-1:0] raddr;
    logic [NUM_REQ-1:0]             ack;
    logic [ADDR_W-1:0]              mux_sel;
    logic [DATA_W-1:0]              mux_out;
    logic                           wr_en;
    logic [ADDR_W-1:0]              wr_addr;
    logic [DATA_W-1:0]              wr_data;
    logic                           rvalid;
    logic [DATA_W-1:0]              rdata;
    logic [IDX_W-1:0]               rid;

    // Arbiter side.
    modport slave (
        input  req, raddr, mux_out, wr_en, wr_addr, wr_data,
        output ack, mux_sel, rvalid, rdata, rid
    );

    // Requester / register file side.
    modport master (
        output req, raddr, mux_out, wr_en, wr_addr, wr_data,
        input  ack, mux_sel, rvalid, rdata, rid
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin picker. Scans req starting
//               at ptr, wrapping modulo N; the first set bit wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic      [N-1:0]     grant,
    output logic      [IDX_W-1:0] gidx,
    output logic                  any_grant
);

    // Rotating priority scan: the first requester at or after ptr wins.
    always_comb begin
        int w_idx;
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        w_idx     = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = (int'(ptr) + i) % N;
            if (!any_grant && req[w_idx]) begin
                any_grant    = 1'b1;
                gidx         = IDX_W'(w_idx);
                grant[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter
// Description : Shares the register file's single read-mux port among
//               NUM_REQ requesters. One round-robin grant per cycle; the
//               selected register is captured and returned one cycle later
//               tagged with the requester index.
//               Optional macro REGFILE_RD_BYPASS_EN forwards a same-cycle
//               register file write to the granted read (except register 31).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = regfile_arb_pkg::ADDR_W,
    parameter int DATA_W  = regfile_arb_pkg::DATA_W
) (
    input  wire logic             clk,
    input  wire logic             reset,
    regfile_read_arbiter_if.slave bus
);

    import regfile_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   r_ptr;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;
    logic [IDX_W-1:0]   r_rid;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_any;
    logic               w_fire;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_rdata_next;
    logic [IDX_W-1:0]   w_ptr_next;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (bus.req),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .gidx      (w_gidx),
        .any_grant (w_any)
    );

    // Reset suppresses the grant so pending requests are dropped and re-arbitrated.
    assign w_fire      = w_any && !reset;
    assign w_sel_addr  = bus.raddr[w_gidx];
    assign bus.ack     = w_fire ? w_grant : '0;
    assign bus.mux_sel = w_fire ? w_sel_addr : '0;

    // Pointer moves one past the winner so it gets lowest priority next cycle.
    assign w_ptr_next = (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + IDX_W'(1);

`ifdef REGFILE_RD_BYPASS_EN
    logic w_bypass_hit;
    // A write to the register being read this cycle is forwarded; r31 never is.
    assign w_bypass_hit = bus.wr_en
                          && (bus.wr_addr == w_sel_addr)
                          && (w_sel_addr != ADDR_W'(ZERO_REG));
    assign w_rdata_next = w_bypass_hit ? bus.wr_data : bus.mux_out;
`else
    logic w_unused_wr;
    // Write port is observed only when forwarding is built in.
    assign w_unused_wr  = ^{bus.wr_en, bus.wr_addr, bus.wr_data};
    assign w_rdata_next = bus.mux_out;
`endif

    // Pointer and response registers: capture on a grant, otherwise hold data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
        end else if (w_fire) begin
            r_ptr    <= w_ptr_next;
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata_next;
            r_rid    <= w_gidx;
        end else begin
            r_rvalid <= 1'b0;
        end
    end

    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
    assign bus.rid    = r_rid;

endmodule
`default_nettype wire
